// File: rtl/stat_ctrl_if.sv
// Retirement-status and debugger handshake bundle between the pipeline and stat_ctrl.
// PC_W/CNT_W must match the parameters of the stat_ctrl instance attached to it.
interface stat_ctrl_if #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) ();
  logic [2:0]       stat_in;
  logic             stat_valid;
  logic [PC_W-1:0]  pc_in;
  logic             dbg_halt_req;
  logic             dbg_step_req;
  logic             dbg_resume_req;
  logic             run_en;
  logic [2:0]       cpu_stat;
  logic [PC_W-1:0]  fault_pc;
  logic             halted;
  logic             paused;
  logic             dbg_ack;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output stat_in, stat_valid, pc_in, dbg_halt_req, dbg_step_req, dbg_resume_req,
    input  run_en, cpu_stat, fault_pc, halted, paused, dbg_ack, cycle_cnt, instr_cnt
  );

  modport slave (
    input  stat_in, stat_valid, pc_in, dbg_halt_req, dbg_step_req, dbg_resume_req,
    output run_en, cpu_stat, fault_pc, halted, paused, dbg_ack, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/stat_ctrl.sv
// Processor status controller: run/pause/step/halt/fault sequencing, fault capture
// and saturating cycle/instruction counters.
module stat_ctrl #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  stat_ctrl_if.slave   bus
);
  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_PAUSE = 3'd1,
    ST_STEP  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [2:0]       STAT_AOK = 3'd1;
  localparam logic [2:0]       STAT_HLT = 3'd2;
  localparam logic [2:0]       STAT_ADR = 3'd3;
  localparam logic [2:0]       STAT_INS = 3'd4;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_r, state_nxt_s;
  logic [2:0]        cpu_stat_r, cpu_stat_nxt_s;
  logic [PC_W-1:0]   fault_pc_r, fault_pc_nxt_s;
  logic              dbg_ack_r, dbg_ack_nxt_s;
  logic              instr_inc_s;
  logic [CNT_W-1:0]  cycle_cnt_r, instr_cnt_r;
  logic              run_en_s, stat_event_s;

  assign run_en_s     = (state_r == ST_RUN) || (state_r == ST_STEP);
  assign stat_event_s = bus.stat_valid && run_en_s;

  // Next-state, fault capture and debugger-acknowledge decode
  always_comb begin
    state_nxt_s    = state_r;
    cpu_stat_nxt_s = cpu_stat_r;
    fault_pc_nxt_s = fault_pc_r;
    dbg_ack_nxt_s  = 1'b0;
    instr_inc_s    = 1'b0;
    case (state_r)
      ST_RUN, ST_STEP: begin
        if (stat_event_s) begin
          if (bus.stat_in == STAT_AOK) begin
            instr_inc_s = 1'b1;
            if ((state_r == ST_STEP) || bus.dbg_halt_req) begin
              state_nxt_s   = ST_PAUSE;
              dbg_ack_nxt_s = 1'b1;
            end else begin
              state_nxt_s = state_r;
            end
          end else begin
            // Any non-AOK retirement terminates, overriding a pending pause request
            fault_pc_nxt_s = bus.pc_in;
            if (bus.stat_in == STAT_HLT) begin
              state_nxt_s    = ST_HALT;
              cpu_stat_nxt_s = STAT_HLT;
            end else if ((bus.stat_in == STAT_ADR) || (bus.stat_in == STAT_INS)) begin
              state_nxt_s    = ST_FAULT;
              cpu_stat_nxt_s = bus.stat_in;
            end else begin
              state_nxt_s    = ST_FAULT;
              cpu_stat_nxt_s = STAT_INS;
            end
          end
        end else if ((state_r == ST_RUN) && bus.dbg_halt_req) begin
          state_nxt_s   = ST_PAUSE;
          dbg_ack_nxt_s = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_PAUSE: begin
        if (bus.dbg_resume_req) begin
          state_nxt_s   = ST_RUN;
          dbg_ack_nxt_s = 1'b1;
        end else if (bus.dbg_step_req) begin
          state_nxt_s = ST_STEP;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_HALT, ST_FAULT: begin
        state_nxt_s = state_r;
      end
      default: begin
        // Corrupted encoding: stop the core rather than guess a live state
        state_nxt_s = ST_FAULT;
      end
    endcase
  end

  // State, captured status and saturating counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      cpu_stat_r  <= STAT_AOK;
      fault_pc_r  <= {PC_W{1'b0}};
      dbg_ack_r   <= 1'b0;
      cycle_cnt_r <= {CNT_W{1'b0}};
      instr_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      cpu_stat_r <= cpu_stat_nxt_s;
      fault_pc_r <= fault_pc_nxt_s;
      dbg_ack_r  <= dbg_ack_nxt_s;
      if (run_en_s && (cycle_cnt_r != CNT_MAX)) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (instr_inc_s && (instr_cnt_r != CNT_MAX)) begin
        instr_cnt_r <= instr_cnt_r + CNT_ONE;
      end else begin
        instr_cnt_r <= instr_cnt_r;
      end
    end
  end

  assign bus.run_en    = run_en_s;
  assign bus.halted    = (state_r == ST_HALT) || (state_r == ST_FAULT);
  assign bus.paused    = (state_r == ST_PAUSE);
  assign bus.cpu_stat  = cpu_stat_r;
  assign bus.fault_pc  = fault_pc_r;
  assign bus.dbg_ack   = dbg_ack_r;
  assign bus.cycle_cnt = cycle_cnt_r;
  assign bus.instr_cnt = instr_cnt_r;
endmodule
